// File: rtl/playback_sequencer_pkg.sv
// Shared types and widths for the playback sequencer: FSM state encoding,
// default widths and the register-file views of the block.
package playback_sequencer_pkg;

  localparam int PB_DATA_W      = 16;
  localparam int PB_DIV_W       = 16;
  localparam int PB_LEVEL_W     = 10;
  localparam int PB_COUNT_W     = 16;
  localparam int PB_PRIME_LEVEL = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    PLAY     = 2'd2,
    UNDERRUN = 2'd3
  } playback_state_t;

  typedef struct packed {
    playback_state_t         playback_state;
    logic [PB_COUNT_W-1:0]   underrun_count;
  } rd_registers_t;

  typedef struct packed {
    logic                    playback_enable;
    logic [PB_DIV_W-1:0]     sample_div;
    logic                    clear_underrun;
  } wr_registers_t;

  // Saturating +1 for the underrun counter.
  function automatic logic [PB_COUNT_W-1:0] sat_inc(input logic [PB_COUNT_W-1:0] v);
    return (v == '1) ? v : v + PB_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// Bundle of FIFO-side, register-side and PWM-side signals of the sequencer.
// master = the sequencer itself, slave = the surrounding FIFO/regfile/PWM.
interface playback_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int DIV_W   = 16,
  parameter int LEVEL_W = 10
);
  logic               ipEnable;
  logic [DIV_W-1:0]   ipSampleDiv;
  logic [LEVEL_W-1:0] ipFIFO_Level;
  logic [DATA_W-1:0]  ipData;
  logic               ipValid;
  logic               ipClearCount;
  logic               opRead;
  logic [DATA_W-1:0]  opSample;
  logic               opSampleStrobe;
  logic [1:0]         opState;
  logic [15:0]        opUnderrunCount;
  logic [7:0]         opPwmDuty;

  modport master (
    input  ipEnable, ipSampleDiv, ipFIFO_Level, ipData, ipValid, ipClearCount,
    output opRead, opSample, opSampleStrobe, opState, opUnderrunCount, opPwmDuty
  );

  modport slave (
    output ipEnable, ipSampleDiv, ipFIFO_Level, ipData, ipValid, ipClearCount,
    input  opRead, opSample, opSampleStrobe, opState, opUnderrunCount, opPwmDuty
  );
endinterface

// File: rtl/playback_sequencer_sample_ticker.sv
// Sample-period down-counter: tick while the count is zero, reload on a pop,
// clear outside active playback; the divisor is only sampled at reload.
module sample_ticker #(
  parameter int DIV_W = 16
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             clear,
  input  logic             reload,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_d, cnt_q;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (reload) begin
      cnt_d = reload_val;
    end else if (!tick) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// Paces FIFO samples into the PWM at one pop per sample period, primes the FIFO
// first and counts underruns. PLAYBACK_UNDERRUN_HOLD_EN keeps the last sample through underruns.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int DATA_W      = PB_DATA_W,
  parameter int DIV_W       = PB_DIV_W,
  parameter int LEVEL_W     = PB_LEVEL_W,
  parameter int PRIME_LEVEL = PB_PRIME_LEVEL
) (
  input  logic                 ipClk,
  input  logic                 ipReset,
  playback_sequencer_if.master bus
);

  localparam logic [LEVEL_W-1:0] PRIME_LVL = LEVEL_W'(PRIME_LEVEL);

  playback_state_t         state_d, state_q;
  logic [DATA_W-1:0]       sample_d, sample_q;
  logic                    strobe_d, strobe_q;
  logic [PB_COUNT_W-1:0]   underrun_count_d, underrun_count_q;
  logic                    tick, play_live, pop, underrun, ticker_clear;
  wr_registers_t           wr;
  rd_registers_t           rd;

  assign wr.playback_enable = bus.ipEnable;
  assign wr.sample_div      = PB_DIV_W'(bus.ipSampleDiv);
  assign wr.clear_underrun  = bus.ipClearCount;

  // Disable and reset both veto the pop in the cycle they arrive.
  assign play_live    = (state_q == PLAY) && wr.playback_enable && !ipReset;
  assign pop          = play_live && tick && bus.ipValid;
  assign underrun     = play_live && tick && !bus.ipValid;
  assign ticker_clear = !play_live || underrun;

  sample_ticker #(.DIV_W(DIV_W)) u_ticker (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .clear      (ticker_clear),
    .reload     (pop),
    .reload_val (bus.ipSampleDiv),
    .tick       (tick)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    strobe_d = pop;
    case (state_q)
      IDLE: begin
        sample_d = '0;
        state_d  = PRIME;
      end
      PRIME: begin
        if (bus.ipFIFO_Level >= PRIME_LVL) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (pop) begin
          sample_d = bus.ipData;
        end else if (underrun) begin
          state_d = UNDERRUN;
`ifndef PLAYBACK_UNDERRUN_HOLD_EN
          sample_d = '0;
`endif
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
    if (!wr.playback_enable) begin
      state_d  = IDLE;
      sample_d = '0;
    end
  end

  // Clear first so a coincident underrun still lands as a count of one.
  always_comb begin
    underrun_count_d = wr.clear_underrun ? '0 : underrun_count_q;
    if (underrun) begin
      underrun_count_d = sat_inc(underrun_count_d);
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q          <= IDLE;
      sample_q         <= '0;
      strobe_q         <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      state_q          <= state_d;
      sample_q         <= sample_d;
      strobe_q         <= strobe_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign rd.playback_state = state_q;
  assign rd.underrun_count = underrun_count_q;

  assign bus.opRead          = pop;
  assign bus.opSample        = sample_q;
  assign bus.opSampleStrobe  = strobe_q;
  assign bus.opState         = rd.playback_state;
  assign bus.opUnderrunCount = rd.underrun_count;
  // PWM wants offset binary: flip the sign bit, keep the top magnitude bits.
  assign bus.opPwmDuty       = {~sample_q[DATA_W-1], sample_q[DATA_W-2 -: 7]};

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed table-driven bench for playback_sequencer with PRIME_LEVEL=4, plus
// hand sequences for counter saturation and clear/underrun coincidence.
module tb_playback_sequencer;
  import playback_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  playback_sequencer_if bus ();

  playback_sequencer #(.PRIME_LEVEL(4)) dut (
    .ipClk   (clk),
    .ipReset (rst),
    .bus     (bus)
  );

`ifdef PLAYBACK_UNDERRUN_HOLD_EN
  localparam logic [15:0] UR1 = 16'h5678;
  localparam logic [15:0] UR2 = 16'h0005;
`else
  localparam logic [15:0] UR1 = 16'h0000;
  localparam logic [15:0] UR2 = 16'h0000;
`endif

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic [9:0]  lvl;
    logic        vld;
    logic [15:0] dat;
    logic        clr;
    logic        rd;
    logic [1:0]  st;
    logic [15:0] smp;
    logic        stb;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic e, input logic [15:0] d,
                              input logic [9:0] l, input logic v, input logic [15:0] da,
                              input logic c, input logic erd, input logic [1:0] est,
                              input logic [15:0] esmp, input logic estb, input logic [15:0] ecnt);
    vec_t x;
    x.rst = r; x.en = e; x.div = d; x.lvl = l; x.vld = v; x.dat = da; x.clr = c;
    x.rd = erd; x.st = est; x.smp = esmp; x.stb = estb; x.cnt = ecnt;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.ipEnable     = v.en;
    bus.ipSampleDiv  = v.div;
    bus.ipFIFO_Level = v.lvl;
    bus.ipValid      = v.vld;
    bus.ipData       = v.dat;
    bus.ipClearCount = v.clr;
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int n = 0;
    while (bus.opState !== s && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, 32'(bus.opState), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst en div  lvl vld dat      clr | rd st smp      stb cnt
    vecs[0]  = mk(0, 1, 3,  3, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 1, 3,  3, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 0);
    vecs[2]  = mk(0, 1, 3,  3, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 0);
    vecs[3]  = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 0);
    vecs[4]  = mk(0, 1, 3,  4, 1, 16'h1234, 0,  1, 2, 16'h0000, 0, 0);
    vecs[5]  = mk(0, 1, 3,  4, 1, 16'h5678, 0,  0, 2, 16'h1234, 1, 0);
    vecs[6]  = mk(0, 1, 3,  4, 1, 16'h5678, 0,  0, 2, 16'h1234, 0, 0);
    vecs[7]  = mk(0, 1, 3,  4, 1, 16'h5678, 0,  0, 2, 16'h1234, 0, 0);
    vecs[8]  = mk(0, 1, 3,  4, 1, 16'h5678, 0,  1, 2, 16'h1234, 0, 0);
    vecs[9]  = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 2, 16'h5678, 1, 0);
    vecs[10] = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 2, 16'h5678, 0, 0);
    vecs[11] = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 2, 16'h5678, 0, 0);
    vecs[12] = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 2, 16'h5678, 0, 0);
    vecs[13] = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 3, UR1,      0, 1);
    vecs[14] = mk(0, 1, 3,  0, 0, 16'h0000, 0,  0, 1, UR1,      0, 1);
    vecs[15] = mk(0, 1, 3,  4, 0, 16'h0000, 0,  0, 1, UR1,      0, 1);
    vecs[16] = mk(0, 1, 1,  4, 1, 16'hABCD, 0,  1, 2, UR1,      0, 1);
    vecs[17] = mk(0, 1, 1,  4, 1, 16'h1111, 0,  0, 2, 16'hABCD, 1, 1);
    vecs[18] = mk(0, 1, 1,  4, 1, 16'h1111, 0,  1, 2, 16'hABCD, 0, 1);
    vecs[19] = mk(0, 1, 1,  4, 1, 16'h2222, 0,  0, 2, 16'h1111, 1, 1);
    vecs[20] = mk(0, 0, 1,  4, 1, 16'h2222, 0,  0, 2, 16'h1111, 0, 1);
    vecs[21] = mk(0, 0, 1,  4, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 1);
    vecs[22] = mk(0, 1, 0,  4, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 1);
    vecs[23] = mk(0, 1, 0,  4, 1, 16'h0001, 0,  0, 1, 16'h0000, 0, 1);
    vecs[24] = mk(0, 1, 0,  4, 1, 16'h0001, 0,  1, 2, 16'h0000, 0, 1);
    vecs[25] = mk(0, 1, 0,  4, 1, 16'h0002, 0,  1, 2, 16'h0001, 1, 1);
    vecs[26] = mk(0, 1, 0,  4, 1, 16'h0003, 0,  1, 2, 16'h0002, 1, 1);
    vecs[27] = mk(0, 1, 0,  4, 1, 16'h0004, 0,  1, 2, 16'h0003, 1, 1);
    vecs[28] = mk(0, 1, 0,  4, 1, 16'h0005, 0,  1, 2, 16'h0004, 1, 1);
    vecs[29] = mk(0, 1, 0,  4, 0, 16'h0000, 0,  0, 2, 16'h0005, 1, 1);
    vecs[30] = mk(0, 1, 0,  4, 0, 16'h0000, 0,  0, 3, UR2,      0, 2);
    vecs[31] = mk(0, 0, 0,  4, 0, 16'h0000, 0,  0, 1, UR2,      0, 2);
    vecs[32] = mk(0, 0, 0,  4, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 2);
    vecs[33] = mk(0, 1, 0,  4, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 2);
    vecs[34] = mk(0, 1, 0,  4, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 2);
    vecs[35] = mk(0, 1, 0,  4, 1, 16'h7777, 0,  1, 2, 16'h0000, 0, 2);
    vecs[36] = mk(1, 1, 0,  4, 1, 16'h8888, 0,  0, 2, 16'h7777, 1, 2);
    vecs[37] = mk(0, 0, 0,  4, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0);

    // Reset held for three cycles with idle inputs.
    rst = 1'b1;
    bus.ipEnable = 1'b0; bus.ipSampleDiv = '0; bus.ipFIFO_Level = '0;
    bus.ipData = '0; bus.ipValid = 1'b0; bus.ipClearCount = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset state",  32'(bus.opState), 32'd0);
    chk("reset sample", 32'(bus.opSample), 32'd0);
    chk("reset read",   32'(bus.opRead), 32'd0);
    chk("reset strobe", 32'(bus.opSampleStrobe), 32'd0);
    chk("reset count",  32'(bus.opUnderrunCount), 32'd0);
    chk("reset duty",   32'(bus.opPwmDuty), 32'h80);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d read", i),   32'(bus.opRead),          32'(vecs[i].rd));
      chk($sformatf("v%0d state", i),  32'(bus.opState),         32'(vecs[i].st));
      chk($sformatf("v%0d sample", i), 32'(bus.opSample),        32'(vecs[i].smp));
      chk($sformatf("v%0d strobe", i), 32'(bus.opSampleStrobe),  32'(vecs[i].stb));
      chk($sformatf("v%0d count", i),  32'(bus.opUnderrunCount), 32'(vecs[i].cnt));
      if (i == 17) chk("duty ABCD", 32'(bus.opPwmDuty), 32'h2B);
    end

    // Saturation: preload near the top, then run repeated underruns.
    @(negedge clk);
    force dut.underrun_count_q = 16'hFFFE;
    #1;
    release dut.underrun_count_q;
    @(negedge clk); #1;
    chk("preload count", 32'(bus.opUnderrunCount), 32'hFFFE);
    bus.ipEnable = 1'b1; bus.ipFIFO_Level = 10'd4; bus.ipValid = 1'b0; bus.ipSampleDiv = '0;
    wait_state(2'd3, "first underrun");
    chk("count to FFFF", 32'(bus.opUnderrunCount), 32'hFFFF);
    @(negedge clk); #1;
    wait_state(2'd3, "second underrun");
    chk("count saturated", 32'(bus.opUnderrunCount), 32'hFFFF);

    // Clear coincident with an underrun tick gives one.
    wait_state(2'd2, "reach play");
    bus.ipClearCount = 1'b1;
    @(negedge clk); #1;
    bus.ipClearCount = 1'b0;
    chk("clr+underrun state", 32'(bus.opState), 32'd3);
    chk("clr+underrun count", 32'(bus.opUnderrunCount), 32'd1);

    // Plain clear while disabling.
    bus.ipClearCount = 1'b1;
    bus.ipEnable = 1'b0;
    @(negedge clk); #1;
    bus.ipClearCount = 1'b0;
    chk("clear count", 32'(bus.opUnderrunCount), 32'd0);
    chk("disable state", 32'(bus.opState), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Paces playback of the streamed sample FIFO into the audio PWM at a programmable sample rate. It sits between the Streamer FIFO output and the PWM duty-cycle input. It primes the FIFO to a fill threshold before starting, pops exactly one sample per sample period, and detects and counts underruns. It exports state and the underrun count for the register file.

## Interface
- DATA_W, 16, sample width (two's complement)
- DIV_W, 16, sample-period divider width
- LEVEL_W, 10, FIFO level width
- PRIME_LEVEL, 256, FIFO level required to leave PRIME
- ipClk  in  1  clock; one clock domain only
- ipReset  in  1  reset; synchronous, active-high
- ipEnable  in  1  run enable (register-driven)
- ipSampleDiv  in  DIV_W  cycles per sample minus 1
- ipFIFO_Level  in  LEVEL_W  current FIFO occupancy
- ipData  in  DATA_W  FIFO head word (first-word-fall-through)
- ipValid  in  1  FIFO non-empty; ipData valid
- opRead  out  1  FIFO pop, combinational
- opSample  out  DATA_W  held sample to PWM
- opSampleStrobe  out  1  one-cycle pulse when opSample updates
- opState  out  2  IDLE=0, PRIME=1, PLAY=2, UNDERRUN=3
- opUnderrunCount  out  16  saturating underrun count
- ipClearCount  in  1  clears opUnderrunCount

## Operation
- **Reset:**
  - state IDLE; tick counter 0.
  - opSample 0, opSampleStrobe 0, opRead 0, opUnderrunCount 0.
- **IDLE:**
  - opSample forced to 0 (PWM midscale).
  - Goes to PRIME when ipEnable=1.
- **PRIME:**
  - Goes to PLAY when ipFIFO_Level >= PRIME_LEVEL.
  - Tick counter loaded with 0 on entry to PLAY.
- **PLAY:**
  - A tick is the counter at 0; otherwise the counter decrements.
  - Tick with ipValid=1:
    - opRead=1.
    - ipData captured into opSample; strobe asserted.
    - Counter reloaded from ipSampleDiv, sampled at the reload.
  - Tick with ipValid=0:
    - opRead=0; go to UNDERRUN.
    - opUnderrunCount increments.
- **UNDERRUN:**
  - Lasts one cycle.
  - opSample set to 0 (see Configuration).
  - Then goes to PRIME.
- **ipEnable=0 in any state:**
  - Next state IDLE.
  - opRead=0 that cycle; disable wins over a simultaneous tick.
  - Counter cleared.
- **opRead** = (state==PLAY) & tick & ipValid & ipEnable. Never asserted outside PLAY.
- **opUnderrunCount:**
  - Saturates at 0xFFFF.
  - ipClearCount with a simultaneous underrun gives 1 (the increment applies after the clear).
- **ipSampleDiv:** 0 gives a pop on every PLAY cycle. A change takes effect at the next reload, never mid-period.

## Timing
- Sample period is ipSampleDiv+1 cycles.
- First tick is the first cycle in PLAY.
- opSample and opSampleStrobe are registered. Both update the cycle after opRead is high.
- PRIME→PLAY decision uses the ipFIFO_Level registered state of the current cycle.
- State transitions take 1 cycle.
- Minimum IDLE→first pop is 2 cycles (IDLE→PRIME→PLAY) when the FIFO is already primed.
- Reset mid-PLAY: IDLE next cycle, no pop, opSample 0, count cleared.

## Configuration
- Macro: PLAYBACK_UNDERRUN_HOLD_EN.
- Defined: opSample holds the last played sample through UNDERRUN and PRIME, and returns to 0 only in IDLE.
- Undefined: opSample is forced to 0 on entry to UNDERRUN and stays 0 until the next pop.

## Structure
- Structures package additions:
  - PLAYBACK_STATE enum (IDLE, PRIME, PLAY, UNDERRUN).
  - Width constants.
  - RD_REGISTERS fields PlaybackState and UnderrunCount.
  - WR_REGISTERS fields PlaybackEnable, SampleDiv and ClearUnderrun.
- Sub-module sample_ticker: down-counter with reload, clear and tick outputs.
- The top level wires opSample to the PWM duty input as {~opSample[15], opSample[14:8]}.

## Test plan
- Assert ipReset for 3 cycles, then release → opState=0, opSample=0, opRead=0, opUnderrunCount=0.
- PRIME_LEVEL=4, div=3, enable, level=3 → state stays 1; level=4 → PLAY. opRead pulses every 4 cycles; opSample shows 0x1234 then 0x5678, each with a one-cycle strobe.
- FIFO runs dry (ipValid=0 at a tick) → no opRead, state 3 for one cycle then 1, count=1, opSample=0x0000. With the macro, opSample holds 0x5678.
- ipEnable dropped on a tick cycle → opRead=0, state 0 next cycle, opSample=0.
- div=0, 5 words queued → opRead high for 5 consecutive cycles, samples in order, then underrun.
- Preload count to 0xFFFF, underrun → stays 0xFFFF; ipClearCount coincident with an underrun → count=1.
